// File: rtl/bip_pkg.sv
// ============================================================================
// Module      : bip_pkg
// Description : Shared widths and operand-select encodings for the BIP
//               accumulator datapath. The instruction decoder uses them too.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bip_pkg;

  localparam int DATA_WIDTH = 16;

  // Operand-B select encodings driven by the decoder's selB bit
  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

endpackage : bip_pkg

`default_nettype wire

// File: rtl/mux2.sv
// ============================================================================
// Module      : mux2
// Description : Parameterized 2:1 combinational word multiplexer, shared by
//               the operand-A and operand-B selectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2
  import bip_pkg::*;
#(
  parameter int DATA_WIDTH = bip_pkg::DATA_WIDTH
) (
  input  logic                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_in0,
  input  logic [DATA_WIDTH-1:0] i_in1,
  output logic [DATA_WIDTH-1:0] o_out
);

  always_comb begin
    o_out = i_in0;
    if (i_sel == SEL_B_IMM) begin
      o_out = i_in1;
    end
  end

endmodule : mux2

`default_nettype wire

// File: rtl/mult_b.sv
// ============================================================================
// Module      : mult_b
// Description : Registered operand-B selector: picks the data-memory word or
//               the sign-extended immediate and presents it to the ALU stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_b
  import bip_pkg::*;
#(
  parameter int                    DATA_WIDTH  = bip_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic                  i_selB,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic [DATA_WIDTH-1:0] i_SIGNAL,
  output logic [DATA_WIDTH-1:0] o_MUL_B,
  output logic                  o_valid,
  output logic                  o_selB
);

  logic [DATA_WIDTH-1:0] w_sel_word;
  logic [DATA_WIDTH-1:0] r_mul_b;
  logic                  r_valid;
  logic                  r_sel_b;

  mux2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux2 (
    .i_sel (i_selB),
    .i_in0 (i_DATA),
    .i_in1 (i_SIGNAL),
    .o_out (w_sel_word)
  );

  // The word is captured regardless of i_valid; consumers qualify with o_valid.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mul_b <= RESET_VALUE;
      r_valid <= 1'b0;
      r_sel_b <= SEL_B_MEM;
    end else if (i_enable) begin
      r_mul_b <= w_sel_word;
      r_valid <= i_valid;
      r_sel_b <= i_selB;
    end
  end

  assign o_MUL_B = r_mul_b;
  assign o_valid = r_valid;
  assign o_selB  = r_sel_b;

endmodule : mult_b

`default_nettype wire

// File: tb/tb_mult_b.sv
// ============================================================================
// Module      : tb_mult_b
// Description : Directed self-checking bench for the operand-B selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_b;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        vld;
  logic        sel;
  logic [15:0] data;
  logic [15:0] sig;
  logic [15:0] mul_b;
  logic        o_vld;
  logic        o_sel;

  int errors = 0;
  int checks = 0;

  mult_b #(
    .DATA_WIDTH  (16),
    .RESET_VALUE (16'h0000)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst_n),
    .i_enable (en),
    .i_valid  (vld),
    .i_selB   (sel),
    .i_DATA   (data),
    .i_SIGNAL (sig),
    .o_MUL_B  (mul_b),
    .o_valid  (o_vld),
    .o_selB   (o_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_mul, input logic e_vld,
                         input logic e_sel);
    chk({tag, ".mul_b"}, mul_b, e_mul);
    chk({tag, ".valid"}, {15'd0, o_vld}, {15'd0, e_vld});
    chk({tag, ".selB"},  {15'd0, o_sel}, {15'd0, e_sel});
  endtask

  initial begin
    logic [15:0] pat;

    // Reset held low while the clock runs
    rst_n = 1'b0; en = 1'b1; vld = 1'b1; sel = 1'b1;
    data  = 16'hF800; sig = 16'h001F;
    #1;
    chk_all("reset_t0", 16'h0000, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk_all("reset_hold", 16'h0000, 1'b0, 1'b0);
    end

    // Memory path
    @(negedge clk); rst_n = 1'b1; sel = 1'b0;
    @(posedge clk); #1;
    chk_all("mem_path", 16'hF800, 1'b1, 1'b0);

    // Immediate path
    @(negedge clk); sel = 1'b1;
    @(posedge clk); #1;
    chk_all("imm_path", 16'h001F, 1'b1, 1'b1);

    // Select toggled between edges has no effect
    #2 sel = 1'b0;
    #1 chk_all("sel_toggle", 16'h001F, 1'b1, 1'b1);

    // Stall for three edges; i_valid ignored
    @(negedge clk); en = 1'b0; sel = 1'b0; data = 16'h1234; vld = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_all("stall", 16'h001F, 1'b1, 1'b1);
    end
    @(negedge clk); en = 1'b1; vld = 1'b1;
    @(posedge clk); #1;
    chk_all("reenable", 16'h1234, 1'b1, 1'b0);

    // Capture with i_valid low still loads the word
    @(negedge clk); vld = 1'b0; data = 16'hBEEF;
    @(posedge clk); #1;
    chk_all("invalid_cap", 16'hBEEF, 1'b0, 1'b0);

    // Async reset between edges
    @(negedge clk); vld = 1'b1; data = 16'hF800; sel = 1'b0;
    @(posedge clk); #1;
    chk_all("pre_async", 16'hF800, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("async_hold", 16'h0000, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1; sel = 1'b1; sig = 16'h5A5A;
    #1 chk_all("release_noedge", 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("post_release", 16'h5A5A, 1'b1, 1'b1);

    // Walking one on immediate, complement on memory word
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pat = 16'h0001 << i;
      sel = 1'b1; sig = pat; data = ~pat;
      @(posedge clk); #1;
      chk($sformatf("walk_sig[%0d]", i), mul_b, pat);
    end

    // Walking one on memory word, complement on immediate
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pat = 16'h0001 << i;
      sel = 1'b0; data = pat; sig = ~pat;
      @(posedge clk); #1;
      chk($sformatf("walk_data[%0d]", i), mul_b, pat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mult_b

`default_nettype wire

// File: doc/mult_b.md
Name: mult_b

Overview:
- Operand-B selector of the BIP accumulator datapath.
- Chooses between the data-memory read word (i_DATA) and the sign-extended instruction immediate (i_SIGNAL) under control of the decoder's selB bit.
- Registers the result so it arrives as a stable operand at the ALU/accumulator input stage.
- Sits between the data memory / sign-extender and the ALU.

Parameters:
- DATA_WIDTH, 16, width of both candidate operands and of o_MUL_B.
- RESET_VALUE, 0, value loaded into o_MUL_B while reset is asserted.

Ports:
- i_clock  input  1  system clock; all state updates on its rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_enable  input  1  stage enable; 0 holds all registered outputs.
- i_valid  input  1  inputs carry a meaningful operand this cycle.
- i_selB  input  1  select: 0 = i_DATA, 1 = i_SIGNAL.
- i_DATA  input  DATA_WIDTH  data-memory read word.
- i_SIGNAL  input  DATA_WIDTH  sign-extended immediate.
- o_MUL_B  output  DATA_WIDTH  registered selected operand.
- o_valid  output  1  o_MUL_B holds an operand captured from a valid cycle.
- o_selB  output  1  registered copy of the select used for the current o_MUL_B (debug/trace).

Behaviour:
- Reset (i_reset low, asynchronous, regardless of clock):
  - o_MUL_B = RESET_VALUE, o_valid = 0, o_selB = 0.
  - All three are held while reset is low.
  - Release takes effect on the next rising edge; no output glitch on release.
- Combinational select: sel_word = i_selB ? i_SIGNAL : i_DATA.
  - Pure bit copy: no sign extension, truncation or arithmetic; every bit passes unchanged.
- Capture on a rising edge with i_reset high:
  - i_enable = 1:
    - o_MUL_B <= sel_word
    - o_selB <= i_selB
    - o_valid <= i_valid
  - i_enable = 0: all outputs hold their previous values; i_valid is ignored.
- Latency is exactly 1 clock from input change to o_MUL_B update when enabled.
- o_MUL_B is captured even when i_valid = 0. Consumers qualify it with o_valid.
- i_selB is sampled only at the capture edge. Toggling it between edges has no effect on outputs.
- Reset mid-operation: outputs return to reset values immediately. The pending capture is discarded; no carry-over.
- No X propagation on outputs after reset. If i_selB is X at a capture edge, the result is implementation-defined; the bench shall not drive X on i_selB.

Decomposition:
- Shared package (bip_pkg):
  - DATA_WIDTH default (16).
  - Select encodings SEL_B_MEM = 1'b0, SEL_B_IMM = 1'b1, which the decoder uses too.
- One natural sub-module, mux2 (parameterized DATA_WIDTH 2:1 combinational mux).
  - Also reused by the operand-A selector.
- The registered stage lives in mult_b.

Test Plan:
- Reset: hold i_reset low, drive i_DATA=16'hF800, i_SIGNAL=16'h001F, i_selB=1, pulse the clock -> o_MUL_B=16'h0000, o_valid=0, o_selB=0 throughout.
- Memory path: release reset, i_enable=1, i_valid=1, i_selB=0, i_DATA=16'hF800, i_SIGNAL=16'h001F -> after 1 edge o_MUL_B=16'hF800, o_valid=1, o_selB=0.
- Immediate path: same data, i_selB=1 -> after next edge o_MUL_B=16'h001F, o_selB=1. Then toggle i_selB mid-cycle without an edge -> o_MUL_B unchanged.
- Stall: o_MUL_B=16'h001F, set i_enable=0, change i_selB=0 and i_DATA=16'h1234 for 3 edges -> o_MUL_B stays 16'h001F. Re-enable -> 16'h1234 after 1 edge.
- Async reset mid-run: o_MUL_B=16'hF800, o_valid=1, drop i_reset between clock edges -> outputs go to 0 before the next edge. Release -> first enabled edge loads the new selection.
- Bit integrity: walking-one over 16 bits on i_SIGNAL with i_selB=1, and on i_DATA with i_selB=0 -> o_MUL_B equals the driven pattern one cycle later for every bit.
